// File: rtl/as_rv_decoder_pipe_if.sv
// as_rv_decoder_pipe_if
// Handshake and bundle bus for the RISC-V decode stage.
//   Upstream side  : i_valid, o_ready, i_inst, i_pc, i_flush, o_flush,
//                    o_rs1_addr, o_rs2_addr (combinational regfile read addresses)
//   Downstream side: o_valid, i_ready and the registered decode bundle
//                    (o_pc, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_funct3,
//                    o_imm, o_alu, o_opcode, o_exception)
//   o_muldiv exists only when AS_RV_MULDIV_EN is defined.
// modport slave is the decode stage, modport master is whoever surrounds it.
interface as_rv_decoder_pipe_if #(
    parameter int XLEN     = 32,
    parameter int ALU_W    = 14,
    parameter int OPCODE_W = 11,
    parameter int EXC_W    = 4
);
    logic                i_valid;
    logic                o_ready;
    logic [31:0]         i_inst;
    logic [XLEN-1:0]     i_pc;
    logic                i_flush;
    logic                o_flush;
    logic [4:0]          o_rs1_addr;
    logic [4:0]          o_rs2_addr;
    logic                o_valid;
    logic                i_ready;
    logic [XLEN-1:0]     o_pc;
    logic [4:0]          o_rs1_addr_q;
    logic [4:0]          o_rs2_addr_q;
    logic [4:0]          o_rd_addr;
    logic [2:0]          o_funct3;
    logic [XLEN-1:0]     o_imm;
    logic [ALU_W-1:0]    o_alu;
    logic [OPCODE_W-1:0] o_opcode;
    logic [EXC_W-1:0]    o_exception;
`ifdef AS_RV_MULDIV_EN
    logic [7:0]          o_muldiv;
`endif

    modport slave (
        input  i_valid, i_inst, i_pc, i_flush, i_ready,
        output o_ready, o_flush, o_rs1_addr, o_rs2_addr, o_valid, o_pc,
               o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_funct3, o_imm,
               o_alu, o_opcode, o_exception
`ifdef AS_RV_MULDIV_EN
        , output o_muldiv
`endif
    );

    modport master (
        output i_valid, i_inst, i_pc, i_flush, i_ready,
        input  o_ready, o_flush, o_rs1_addr, o_rs2_addr, o_valid, o_pc,
               o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_funct3, o_imm,
               o_alu, o_opcode, o_exception
`ifdef AS_RV_MULDIV_EN
        , input o_muldiv
`endif
    );
endinterface

// File: rtl/as_rv_decoder_pipe.sv
// as_rv_decoder_pipe
// RV32I/RV64I decode stage sitting between fetch and execute. One instruction
// per cycle is decoded into one-hot ALU and opcode-class vectors, an XLEN-wide
// immediate and exception flags. A 2-entry skid buffer (output register + skid
// register) keeps o_ready a pure register output.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset
//   bus    - as_rv_decoder_pipe_if.slave (handshakes, instruction in, bundle out)
// Optional feature macro: AS_RV_MULDIV_EN adds o_muldiv and makes funct7=0000001
// RTYPE instructions legal M-extension ops instead of ILLEGAL.
module as_rv_decoder_pipe #(
    parameter int XLEN     = 32,
    parameter int ALU_W    = 14,
    parameter int OPCODE_W = 11,
    parameter int EXC_W    = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    as_rv_decoder_pipe_if.slave bus
);
    localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5, A_AND = 6;
    localparam int A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;
    localparam int OC_RTYPE = 0, OC_ITYPE = 1, OC_LOAD = 2, OC_STORE = 3, OC_BRANCH = 4, OC_JAL = 5;
    localparam int OC_JALR = 6, OC_LUI = 7, OC_AUIPC = 8, OC_SYSTEM = 9, OC_FENCE = 10;
    localparam int E_ILLEGAL = 0, E_ECALL = 1, E_EBREAK = 2, E_MRET = 3;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [XLEN-1:0]     imm;
        logic [ALU_W-1:0]    alu;
        logic [OPCODE_W-1:0] opcode;
        logic [EXC_W-1:0]    exc;
`ifdef AS_RV_MULDIV_EN
        logic [7:0]          muldiv;
`endif
    } bundle_t;

    bundle_t     decoded_d;
    bundle_t     outBundle_q;
    bundle_t     skidBundle_q;
    logic        outValid_q;
    logic        skidValid_q;
    logic        accept;
    logic [31:0] inst;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic        immSigned;

    // Shared RTYPE/ITYPE funct3 table; inst[30] picks SUB only when allowed and SRA always.
    function automatic logic [ALU_W-1:0] arithAlu(input logic [2:0] f3, input logic alt,
                                                  input logic subOk);
        logic [ALU_W-1:0] r;
        r = '0;
        case (f3)
            3'b000:  r[(subOk && alt) ? A_SUB : A_ADD] = 1'b1;
            3'b001:  r[A_SLL] = 1'b1;
            3'b010:  r[A_SLT] = 1'b1;
            3'b011:  r[A_SLTU] = 1'b1;
            3'b100:  r[A_XOR] = 1'b1;
            3'b101:  r[alt ? A_SRA : A_SRL] = 1'b1;
            3'b110:  r[A_OR] = 1'b1;
            default: r[A_AND] = 1'b1;
        endcase
        return r;
    endfunction

    // Branch comparisons; the two reserved funct3 codes fall back to ADD.
    function automatic logic [ALU_W-1:0] branchAlu(input logic [2:0] f3);
        logic [ALU_W-1:0] r;
        r = '0;
        case (f3)
            3'b000:  r[A_EQ] = 1'b1;
            3'b001:  r[A_NEQ] = 1'b1;
            3'b100:  r[A_SLT] = 1'b1;
            3'b101:  r[A_GE] = 1'b1;
            3'b110:  r[A_SLTU] = 1'b1;
            3'b111:  r[A_GEU] = 1'b1;
            default: r[A_ADD] = 1'b1;
        endcase
        return r;
    endfunction

    assign inst   = bus.i_inst;
    assign funct7 = inst[31:25];
    assign funct3 = inst[14:12];

    // Pure decode of the incoming word. Immediates are built as 32-bit values and
    // widened once at the end, sign- or zero-extended depending on the class.
    always_comb begin
        decoded_d          = '0;
        imm32              = '0;
        immSigned          = 1'b1;
        decoded_d.pc       = bus.i_pc;
        decoded_d.rs1      = inst[19:15];
        decoded_d.rs2      = inst[24:20];
        decoded_d.rd       = inst[11:7];
        decoded_d.funct3   = funct3;
        decoded_d.alu[A_ADD] = 1'b1;
        case (inst[6:0])
            7'b0110011: begin
                decoded_d.opcode[OC_RTYPE] = 1'b1;
                decoded_d.alu = arithAlu(funct3, inst[30], 1'b1);
                if (funct7 == 7'b0000001) begin
`ifdef AS_RV_MULDIV_EN
                    decoded_d.alu            = '0;
                    decoded_d.muldiv[funct3] = 1'b1;
`else
                    decoded_d.exc[E_ILLEGAL] = 1'b1;
`endif
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    decoded_d.exc[E_ILLEGAL] = 1'b1;
                end
            end
            7'b0010011: begin
                decoded_d.opcode[OC_ITYPE] = 1'b1;
                decoded_d.alu = arithAlu(funct3, inst[30], 1'b0);
                imm32 = {{20{inst[31]}}, inst[31:20]};
                // shamt[5] only exists on RV64
                if ((funct3 == 3'b001 || funct3 == 3'b101) && (XLEN == 32) && inst[25])
                    decoded_d.exc[E_ILLEGAL] = 1'b1;
            end
            7'b0000011: begin
                decoded_d.opcode[OC_LOAD] = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                decoded_d.opcode[OC_STORE] = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                decoded_d.opcode[OC_BRANCH] = 1'b1;
                decoded_d.alu = branchAlu(funct3);
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b1101111: begin
                decoded_d.opcode[OC_JAL] = 1'b1;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin
                decoded_d.opcode[OC_JALR] = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0110111: begin
                decoded_d.opcode[OC_LUI] = 1'b1;
                imm32 = {inst[31:12], 12'b0};
            end
            7'b0010111: begin
                decoded_d.opcode[OC_AUIPC] = 1'b1;
                imm32 = {inst[31:12], 12'b0};
            end
            7'b1110011: begin
                decoded_d.opcode[OC_SYSTEM] = 1'b1;
                imm32     = {20'b0, inst[31:20]};
                immSigned = 1'b0;
                if (funct3 == 3'b000) begin
                    case (inst[21:20])
                        2'b00:   decoded_d.exc[E_ECALL] = 1'b1;
                        2'b01:   decoded_d.exc[E_EBREAK] = 1'b1;
                        2'b10:   decoded_d.exc[E_MRET] = 1'b1;
                        default: ;
                    endcase
                end
            end
            7'b0001111: begin
                decoded_d.opcode[OC_FENCE] = 1'b1;
                imm32     = {20'b0, inst[31:20]};
                immSigned = 1'b0;
            end
            default: decoded_d.exc[E_ILLEGAL] = 1'b1;
        endcase
        decoded_d.imm = immSigned ? XLEN'($signed(imm32)) : XLEN'(imm32);
    end

    // o_ready is just the inverted skid flag, so accepting never depends on i_ready.
    assign accept = bus.i_valid && !skidValid_q;

    // Output register plus skid register. The skid only fills when the output is
    // stalled, and it always drains before a new word can be accepted, which keeps
    // instructions in order. Flush wins over everything except reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outValid_q   <= 1'b0;
            skidValid_q  <= 1'b0;
            outBundle_q  <= '0;
            skidBundle_q <= '0;
        end else if (bus.i_flush) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
        end else if (!outValid_q || bus.i_ready) begin
            if (skidValid_q) begin
                outBundle_q <= skidBundle_q;
                outValid_q  <= 1'b1;
                skidValid_q <= 1'b0;
            end else if (accept) begin
                outBundle_q <= decoded_d;
                outValid_q  <= 1'b1;
            end else begin
                outValid_q <= 1'b0;
            end
        end else if (accept) begin
            skidBundle_q <= decoded_d;
            skidValid_q  <= 1'b1;
        end
    end

    assign bus.o_ready      = !skidValid_q;
    assign bus.o_flush      = bus.i_flush;
    assign bus.o_rs1_addr   = inst[19:15];
    assign bus.o_rs2_addr   = inst[24:20];
    assign bus.o_valid      = outValid_q;
    assign bus.o_pc         = outBundle_q.pc;
    assign bus.o_rs1_addr_q = outBundle_q.rs1;
    assign bus.o_rs2_addr_q = outBundle_q.rs2;
    assign bus.o_rd_addr    = outBundle_q.rd;
    assign bus.o_funct3     = outBundle_q.funct3;
    assign bus.o_imm        = outBundle_q.imm;
    assign bus.o_alu        = outBundle_q.alu;
    assign bus.o_opcode     = outBundle_q.opcode;
    assign bus.o_exception  = outBundle_q.exc;
`ifdef AS_RV_MULDIV_EN
    assign bus.o_muldiv     = outBundle_q.muldiv;
`endif
endmodule

// File: tb/tb_as_rv_decoder_pipe.sv
// tb_as_rv_decoder_pipe
// Directed bench for the decode stage. Two instances share the same stimulus:
// dut32 (XLEN=32) carries most checks, dut64 (XLEN=64) covers RV64 shamt
// legality and 64-bit sign extension.
module tb_as_rv_decoder_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    as_rv_decoder_pipe_if #(.XLEN(32)) bus32 ();
    as_rv_decoder_pipe_if #(.XLEN(64)) bus64 ();

    as_rv_decoder_pipe #(.XLEN(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32.slave));
    as_rv_decoder_pipe #(.XLEN(64)) dut64 (.i_clk(clk), .i_rst(rst), .bus(bus64.slave));

    // Decode vectors: instruction, expected ALU, opcode class, exceptions, imm (XLEN=32)
    localparam int NVEC = 16;
    logic [31:0] vecInst [NVEC] = '{32'h403100B3, 32'h4030D093, 32'h800002B7, 32'hFE20AC23,
                                    32'hFE000EE3, 32'hFE007EE3, 32'h008000EF, 32'h00000073,
                                    32'h00100073, 32'h30200073, 32'h0FF0000F, 32'h0000007F,
                                    32'h04000033, 32'hFFF100E7, 32'h00412083, 32'h02009093};
    logic [13:0] vecAlu  [NVEC] = '{14'h0002, 14'h0200, 14'h0001, 14'h0001,
                                    14'h0400, 14'h2000, 14'h0001, 14'h0001,
                                    14'h0001, 14'h0001, 14'h0001, 14'h0001,
                                    14'h0001, 14'h0001, 14'h0001, 14'h0080};
    logic [10:0] vecOpc  [NVEC] = '{11'h001, 11'h002, 11'h080, 11'h008,
                                    11'h010, 11'h010, 11'h020, 11'h200,
                                    11'h200, 11'h200, 11'h400, 11'h000,
                                    11'h001, 11'h040, 11'h004, 11'h002};
    logic [3:0]  vecExc  [NVEC] = '{4'h0, 4'h0, 4'h0, 4'h0,
                                    4'h0, 4'h0, 4'h0, 4'h2,
                                    4'h4, 4'h8, 4'h0, 4'h1,
                                    4'h1, 4'h0, 4'h0, 4'h1};
    logic [31:0] vecImm  [NVEC] = '{32'h00000000, 32'h00000403, 32'h80000000, 32'hFFFFFFF8,
                                    32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008, 32'h00000000,
                                    32'h00000001, 32'h00000302, 32'h000000FF, 32'h00000000,
                                    32'h00000000, 32'hFFFFFFFF, 32'h00000004, 32'h00000020};

    // Drive both instances with the same upstream/downstream inputs
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        bus32.i_valid = v;   bus64.i_valid = v;
        bus32.i_inst  = inst; bus64.i_inst = inst;
        bus32.i_pc    = pc;  bus64.i_pc    = {32'b0, pc};
        bus32.i_ready = rdy; bus64.i_ready = rdy;
        bus32.i_flush = fl;  bus64.i_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset valid got=%0h exp=0", bus32.o_valid); end
        total++; if (bus32.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset ready got=%0h exp=1", bus32.o_ready); end
        total++; if (bus32.o_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset pc got=%h exp=0", bus32.o_pc); end
        total++; if (bus32.o_alu !== 14'h0) begin bad++; $display("[TB] FAIL reset alu got=%h exp=0", bus32.o_alu); end
        total++; if (bus32.o_opcode !== 11'h0) begin bad++; $display("[TB] FAIL reset opcode got=%h exp=0", bus32.o_opcode); end
        total++; if (bus32.o_imm !== 32'h0) begin bad++; $display("[TB] FAIL reset imm got=%h exp=0", bus32.o_imm); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(1'b1, 32'h002081B3, 32'h00000100, 1'b1, 1'b0);
        #1;
        total++; if (bus32.o_rs1_addr !== 5'd1) begin bad++; $display("[TB] FAIL add rs1 comb got=%0d exp=1", bus32.o_rs1_addr); end
        total++; if (bus32.o_rs2_addr !== 5'd2) begin bad++; $display("[TB] FAIL add rs2 comb got=%0d exp=2", bus32.o_rs2_addr); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (bus32.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL add valid got=%0h exp=1", bus32.o_valid); end
        total++; if (bus32.o_alu !== 14'h0001) begin bad++; $display("[TB] FAIL add alu got=%h exp=0001", bus32.o_alu); end
        total++; if (bus32.o_opcode !== 11'h001) begin bad++; $display("[TB] FAIL add opcode got=%h exp=001", bus32.o_opcode); end
        total++; if (bus32.o_rd_addr !== 5'd3) begin bad++; $display("[TB] FAIL add rd got=%0d exp=3", bus32.o_rd_addr); end
        total++; if (bus32.o_rs1_addr_q !== 5'd1) begin bad++; $display("[TB] FAIL add rs1_q got=%0d exp=1", bus32.o_rs1_addr_q); end
        total++; if (bus32.o_rs2_addr_q !== 5'd2) begin bad++; $display("[TB] FAIL add rs2_q got=%0d exp=2", bus32.o_rs2_addr_q); end
        total++; if (bus32.o_pc !== 32'h100) begin bad++; $display("[TB] FAIL add pc got=%h exp=100", bus32.o_pc); end
        total++; if (bus32.o_exception !== 4'h0) begin bad++; $display("[TB] FAIL add exc got=%h exp=0", bus32.o_exception); end
        tick();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL add idle valid got=%0h exp=0", bus32.o_valid); end
    endtask

    task automatic test_decode_vectors();
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecInst[i], 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            tick();
            total++; if (bus32.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL vec%0d valid got=%0h exp=1", i, bus32.o_valid); end
            total++; if (bus32.o_pc !== 32'h1000 + 32'(i * 4)) begin bad++; $display("[TB] FAIL vec%0d pc got=%h exp=%h", i, bus32.o_pc, 32'h1000 + 32'(i * 4)); end
            total++; if (bus32.o_alu !== vecAlu[i]) begin bad++; $display("[TB] FAIL vec%0d alu got=%h exp=%h", i, bus32.o_alu, vecAlu[i]); end
            total++; if (bus32.o_opcode !== vecOpc[i]) begin bad++; $display("[TB] FAIL vec%0d opcode got=%h exp=%h", i, bus32.o_opcode, vecOpc[i]); end
            total++; if (bus32.o_exception !== vecExc[i]) begin bad++; $display("[TB] FAIL vec%0d exc got=%h exp=%h", i, bus32.o_exception, vecExc[i]); end
            total++; if (bus32.o_imm !== vecImm[i]) begin bad++; $display("[TB] FAIL vec%0d imm got=%h exp=%h", i, bus32.o_imm, vecImm[i]); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_xlen64();
        drive(1'b1, 32'h02009093, 32'h0, 1'b1, 1'b0);
        tick();
        total++; if (bus64.o_exception !== 4'h0) begin bad++; $display("[TB] FAIL rv64 slli exc got=%h exp=0", bus64.o_exception); end
        total++; if (bus64.o_alu !== 14'h0080) begin bad++; $display("[TB] FAIL rv64 slli alu got=%h exp=0080", bus64.o_alu); end
        total++; if (bus64.o_imm !== 64'h20) begin bad++; $display("[TB] FAIL rv64 slli imm got=%h exp=20", bus64.o_imm); end
        drive(1'b1, 32'hFE000EE3, 32'h0, 1'b1, 1'b0);
        tick();
        total++; if (bus64.o_imm !== 64'hFFFFFFFFFFFFFFFC) begin bad++; $display("[TB] FAIL rv64 beq imm got=%h exp=FFFFFFFFFFFFFFFC", bus64.o_imm); end
        total++; if (bus64.o_alu !== 14'h0400) begin bad++; $display("[TB] FAIL rv64 beq alu got=%h exp=0400", bus64.o_alu); end
        drive(1'b1, 32'h800002B7, 32'h0, 1'b1, 1'b0);
        tick();
        total++; if (bus64.o_imm !== 64'hFFFFFFFF80000000) begin bad++; $display("[TB] FAIL rv64 lui imm got=%h exp=FFFFFFFF80000000", bus64.o_imm); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_mul();
        drive(1'b1, 32'h023100B3, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (bus32.o_opcode !== 11'h001) begin bad++; $display("[TB] FAIL mul opcode got=%h exp=001", bus32.o_opcode); end
`ifdef AS_RV_MULDIV_EN
        total++; if (bus32.o_muldiv !== 8'h01) begin bad++; $display("[TB] FAIL mul muldiv got=%h exp=01", bus32.o_muldiv); end
        total++; if (bus32.o_exception !== 4'h0) begin bad++; $display("[TB] FAIL mul exc got=%h exp=0", bus32.o_exception); end
        total++; if (bus32.o_alu !== 14'h0) begin bad++; $display("[TB] FAIL mul alu got=%h exp=0", bus32.o_alu); end
`else
        total++; if (bus32.o_exception !== 4'h1) begin bad++; $display("[TB] FAIL mul exc got=%h exp=1", bus32.o_exception); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h00100093, 32'h200, 1'b1, 1'b0);
        tick();
        total++; if (bus32.o_pc !== 32'h200) begin bad++; $display("[TB] FAIL b2b first pc got=%h exp=200", bus32.o_pc); end
        drive(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
        tick();
        total++; if (bus32.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b skid ready got=%0h exp=0", bus32.o_ready); end
        total++; if (bus32.o_pc !== 32'h200) begin bad++; $display("[TB] FAIL b2b hold pc got=%h exp=200", bus32.o_pc); end
        drive(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
        tick();
        total++; if (bus32.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b held valid got=%0h exp=1", bus32.o_valid); end
        total++; if (bus32.o_pc !== 32'h200) begin bad++; $display("[TB] FAIL b2b still held pc got=%h exp=200", bus32.o_pc); end
        total++; if (bus32.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b still full ready got=%0h exp=0", bus32.o_ready); end
        drive(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
        tick();
        total++; if (bus32.o_pc !== 32'h204) begin bad++; $display("[TB] FAIL b2b drain pc got=%h exp=204", bus32.o_pc); end
        total++; if (bus32.o_imm !== 32'h2) begin bad++; $display("[TB] FAIL b2b drain imm got=%h exp=2", bus32.o_imm); end
        total++; if (bus32.o_rd_addr !== 5'd2) begin bad++; $display("[TB] FAIL b2b drain rd got=%0d exp=2", bus32.o_rd_addr); end
        total++; if (bus32.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b drain ready got=%0h exp=1", bus32.o_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (bus32.o_pc !== 32'h208) begin bad++; $display("[TB] FAIL b2b third pc got=%h exp=208", bus32.o_pc); end
        total++; if (bus32.o_imm !== 32'h3) begin bad++; $display("[TB] FAIL b2b third imm got=%h exp=3", bus32.o_imm); end
        total++; if (bus32.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b third valid got=%0h exp=1", bus32.o_valid); end
        tick();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b empty valid got=%0h exp=0", bus32.o_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00100093, 32'h300, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
        tick();
        total++; if (bus32.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush prefill ready got=%0h exp=0", bus32.o_ready); end
        drive(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b1);
        #1;
        total++; if (bus32.o_flush !== 1'b1) begin bad++; $display("[TB] FAIL flush comb got=%0h exp=1", bus32.o_flush); end
        tick();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush valid got=%0h exp=0", bus32.o_valid); end
        total++; if (bus32.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush ready got=%0h exp=1", bus32.o_ready); end
        drive(1'b1, 32'h00400213, 32'h30C, 1'b1, 1'b1);
        tick();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush drops accept valid got=%0h exp=0", bus32.o_valid); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush nothing emitted valid got=%0h exp=0", bus32.o_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h00100093, 32'h400, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset valid got=%0h exp=0", bus32.o_valid); end
        total++; if (bus32.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset ready got=%0h exp=1", bus32.o_ready); end
        total++; if (bus32.o_pc !== 32'h0) begin bad++; $display("[TB] FAIL midreset pc got=%h exp=0", bus32.o_pc); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset no partial valid got=%0h exp=0", bus32.o_valid); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #12;
        test_reset();
        test_add();
        test_decode_vectors();
        test_xlen64();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
